axil_gpio_irq: RTL and testbench

AXI-Lite slave that consumes the GPIO pin vector, synchronises it into the clock domain, detects programmable edges per pin and raises a level interrupt. It sits downstream of the bidirectional GPIO pad block, tapped on the same `gpio` net, and is mapped on the peripheral AXI-Lite bus next to it. It gives software edge-event capture with per-pin enable and write-1-to-clear status.

---
 rtl/axil_gpio_irq.sv | 190 +++++++++++++++++++
 tb/tb_axil_gpio_irq.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_gpio_irq.sv
// AXI-Lite GPIO edge-event capture: synchronised pin levels, per-pin polarity,
// write-1-to-clear status and a registered level interrupt.
module axil_gpio_irq #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int N_GPIO     = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,
    input  logic [N_GPIO-1:0]     gpio_in,
    output logic                  irq
);

    typedef enum logic [1:0] {
        BANK_PIN    = 2'd0,
        BANK_IE     = 2'd1,
        BANK_POL    = 2'd2,
        BANK_STATUS = 2'd3
    } bank_e;

    localparam logic [63:0] PIN_MASK = (N_GPIO >= 64) ? {64{1'b1}}
                                                      : ((64'd1 << N_GPIO) - 64'd1);

    logic [63:0] gpio_ext;
    logic [63:0] s1_q, s2_q, s3_q;
    logic [63:0] ie_q, ie_d, pol_q, pol_d, status_q, status_d;
    logic [1:0]  warm_q, warm_d;
    logic        irq_q, irq_d;

    logic                  awready_q, awready_d, wready_q, wready_d;
    logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic                  bvalid_q, bvalid_d;
    logic [2:0]            awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;

    logic                  arready_q, arready_d, ar_pend_q, ar_pend_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic        commit, aw_hs, w_hs, ar_hs;
    logic [31:0] wm32;
    logic [63:0] wm64, wd64, clr, rise, fall, evt, rd_sel;
    bank_e       wbank, rbank;

    logic unused_ok;
    assign unused_ok = ^{s_axil_awprot, s_axil_arprot,
                         s_axil_awaddr[ADDR_WIDTH-1:5], s_axil_awaddr[1:0],
                         s_axil_araddr[ADDR_WIDTH-1:5], s_axil_araddr[1:0]};

    assign gpio_ext = 64'(gpio_in);

    always_comb begin
        aw_hs  = s_axil_awvalid & awready_q;
        w_hs   = s_axil_wvalid & wready_q;
        commit = aw_held_q & w_held_q & ~bvalid_q;

        // New beats are held off until the pending response has been taken.
        awready_d = s_axil_awvalid & ~awready_q & ~aw_held_q & ~bvalid_q;
        wready_d  = s_axil_wvalid & ~wready_q & ~w_held_q & ~bvalid_q;
        aw_held_d = commit ? 1'b0 : (aw_hs | aw_held_q);
        w_held_d  = commit ? 1'b0 : (w_hs | w_held_q);
        awaddr_d  = aw_hs ? s_axil_awaddr[4:2] : awaddr_q;
        wdata_d   = w_hs ? s_axil_wdata : wdata_q;
        wstrb_d   = w_hs ? s_axil_wstrb : wstrb_q;
        bvalid_d  = commit ? 1'b1 : (bvalid_q & ~s_axil_bready);

        wm32 = '0;
        for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
            wm32[b*8 +: 8] = {8{wstrb_q[b]}};
        end
        wm64  = awaddr_q[0] ? {wm32, 32'h0} : {32'h0, wm32};
        wd64  = {wdata_q, wdata_q};
        wbank = bank_e'(awaddr_q[2:1]);

        ie_d  = ie_q;
        pol_d = pol_q;
        clr   = '0;
        if (commit) begin
            unique case (wbank)
                BANK_IE:     ie_d  = ((ie_q & ~wm64) | (wd64 & wm64)) & PIN_MASK;
                BANK_POL:    pol_d = ((pol_q & ~wm64) | (wd64 & wm64)) & PIN_MASK;
                BANK_STATUS: clr   = wd64 & wm64;
                default:     ;
            endcase
        end

        rise     = s2_q & ~s3_q;
        fall     = ~s2_q & s3_q;
        evt      = (warm_q == 2'd3) ? ((pol_q & rise) | (~pol_q & fall)) : '0;
        // A fresh event overrides a simultaneous clear of the same bit.
        status_d = ((status_q & ~clr) | evt) & PIN_MASK;
        warm_d   = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
        irq_d    = |(status_q & ie_q);

        ar_hs     = s_axil_arvalid & arready_q;
        arready_d = s_axil_arvalid & ~arready_q & ~ar_pend_q & ~rvalid_q;
        ar_pend_d = ar_hs;
        rvalid_d  = ar_pend_q | (rvalid_q & ~s_axil_rready);
        rbank     = bank_e'(s_axil_araddr[4:3]);
        unique case (rbank)
            BANK_PIN:    rd_sel = s2_q;
            BANK_IE:     rd_sel = ie_q;
            BANK_POL:    rd_sel = pol_q;
            BANK_STATUS: rd_sel = status_q;
            default:     rd_sel = '0;
        endcase
        rdata_d = rdata_q;
        if (ar_hs) begin
            rdata_d = s_axil_araddr[2] ? rd_sel[63:32] : rd_sel[31:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            ie_q      <= '0;
            pol_q     <= '0;
            status_q  <= '0;
            warm_q    <= '0;
            irq_q     <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            arready_q <= 1'b0;
            ar_pend_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            s1_q      <= gpio_ext;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            ie_q      <= ie_d;
            pol_q     <= pol_d;
            status_q  <= status_d;
            warm_q    <= warm_d;
            irq_q     <= irq_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            bvalid_q  <= bvalid_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            arready_q <= arready_d;
            ar_pend_q <= ar_pend_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign s_axil_awready = awready_q;
    assign s_axil_wready  = wready_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = 2'b00;
    assign s_axil_arready = arready_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = 2'b00;
    assign irq            = irq_q;

endmodule

// File: tb/tb_axil_gpio_irq.sv
// Directed bench for axil_gpio_irq: edge capture, W1C, strobes and AXI-Lite handshakes.
module tb_axil_gpio_irq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic [63:0] gpio_in;
    logic        irq;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axil_gpio_irq #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .N_GPIO(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid),
        .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid),
        .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid),
        .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid),
        .s_axil_rready(rready),
        .gpio_in(gpio_in), .irq(irq)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        logic aw_done, w_done, aw_hs, w_hs;
        int   cnt;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; cnt = 0;
        resp = 2'b11;
        while (!(aw_done && w_done) && cnt < 20) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick(1);
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin wvalid = 1'b0; w_done = 1'b1; end
            cnt++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        checks++;
        if (!(aw_done && w_done)) begin
            errors++;
            $display("FAIL wr_accept addr=%h got aw=%0b w=%0b expected 1 1", addr, aw_done, w_done);
        end
        bready = 1'b1; cnt = 0;
        while (!bvalid && cnt < 20) begin tick(1); cnt++; end
        checks++;
        if (!bvalid) begin
            errors++;
            $display("FAIL wr_bvalid addr=%h got bvalid=0 expected 1", addr);
        end else begin
            resp = bresp;
            tick(1);
        end
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
        logic ar_hs, done;
        int   cnt;
        araddr = addr; arvalid = 1'b1; done = 1'b0; cnt = 0;
        data = 32'hDEAD_BEEF;
        while (!done && cnt < 20) begin
            ar_hs = arvalid && arready;
            tick(1);
            if (ar_hs) begin arvalid = 1'b0; done = 1'b1; end
            cnt++;
        end
        arvalid = 1'b0;
        rready = 1'b1; cnt = 0;
        while (!rvalid && cnt < 20) begin tick(1); cnt++; end
        checks++;
        if (!rvalid) begin
            errors++;
            $display("FAIL rd_timeout addr=%h got rvalid=0 expected 1", addr);
        end else begin
            data = rdata;
            tick(1);
        end
        rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0;
        tick(3);
        checks++;
        if ({awready, wready, bvalid, arready, rvalid, irq} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b expected 000000",
                     {awready, wready, bvalid, arready, rvalid, irq});
        end
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got %h expected 00000000", rdata);
        end
        rst_n = 1'b1;
        tick(6);
        axi_read(32'h08, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_ie got %h expected 00000000", d); end
        axi_read(32'h18, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_status got %h expected 00000000", d); end
    endtask

    task automatic test_rise_pin3();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(32'h10, 32'h8, 4'hF, r);
        axi_write(32'h08, 32'h8, 4'hF, r);
        gpio_in[3] = 1'b1;
        tick(3);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL rise_irq_early got %b expected 0", irq); end
        tick(1);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL rise_irq_k3 got %b expected 1", irq); end
        axi_read(32'h18, d);
        checks++;
        if (d !== 32'h0000_0008) begin errors++; $display("FAIL rise_status got %h expected 00000008", d); end
        axi_write(32'h18, 32'h8, 4'hF, r);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL rise_w1c_irq got %b expected 0", irq); end
        axi_read(32'h18, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rise_w1c_status got %h expected 00000000", d); end
    endtask

    task automatic test_fall_pin40();
        logic [31:0] d;
        logic [1:0]  r;
        gpio_in[40] = 1'b1;
        tick(4);
        axi_write(32'h0C, 32'h100, 4'hF, r);
        axi_read(32'h1C, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL fall_rise_ignored got %h expected 00000000", d); end
        gpio_in[40] = 1'b0;
        tick(4);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL fall_irq got %b expected 1", irq); end
        axi_read(32'h1C, d);
        checks++;
        if (d !== 32'h0000_0100) begin errors++; $display("FAIL fall_status got %h expected 00000100", d); end
        axi_write(32'h1C, 32'h100, 4'hF, r);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL fall_w1c_irq got %b expected 0", irq); end
        axi_read(32'h1C, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL fall_w1c_status got %h expected 00000000", d); end
    endtask

    task automatic test_w1c_collision();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(32'h10, 32'h28, 4'hF, r);
        tick(1);
        // pin edge and W1C commit both land on the same clock edge
        gpio_in[5] = 1'b1;
        axi_write(32'h18, 32'h20, 4'hF, r);
        axi_read(32'h18, d);
        checks++;
        if (d !== 32'h0000_0020) begin errors++; $display("FAIL collide_status got %h expected 00000020", d); end
        axi_write(32'h18, 32'h20, 4'hF, r);
        axi_read(32'h18, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL collide_clear got %h expected 00000000", d); end
    endtask

    task automatic test_strobe();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(32'h08, 32'hAABBCCDD, 4'b0101, r);
        axi_read(32'h08, d);
        checks++;
        if (d !== 32'h00BB00DD) begin errors++; $display("FAIL strobe_ie got %h expected 00bb00dd", d); end
        axi_write(32'h08, 32'h0, 4'hF, r);
    endtask

    task automatic test_pin_ro();
        logic [31:0] d, exp_lo;
        logic [1:0]  r;
        axi_write(32'h00, 32'h1234, 4'hF, r);
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL pin_wr_resp got %b expected 00", r); end
        exp_lo = gpio_in[31:0];
        axi_read(32'h00, d);
        checks++;
        if (d !== exp_lo) begin errors++; $display("FAIL pin_lo got %h expected %h", d, exp_lo); end
        axi_read(32'h04, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL pin_hi got %h expected 00000000", d); end
        axi_read(32'h2C, d);
        checks++;
        if (d !== 32'h100) begin errors++; $display("FAIL alias_ie_hi got %h expected 00000100", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic        hs, aw_hs, w_hs, aw_done, w_done;
        int          wacc, stray, bhigh, cnt;
        wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1; awaddr = 32'h14; awvalid = 1'b0;
        bready = 1'b0; wacc = 0;
        for (int i = 0; i < 5; i++) begin
            hs = wvalid && wready;
            tick(1);
            if (hs) begin wvalid = 1'b0; wacc++; end
        end
        checks++;
        if (wacc != 1) begin errors++; $display("FAIL b2b_w_early got %0d expected 1", wacc); end
        awvalid = 1'b1; cnt = 0; aw_done = 1'b0;
        while (!aw_done && cnt < 10) begin
            hs = awvalid && awready;
            tick(1);
            if (hs) begin awvalid = 1'b0; aw_done = 1'b1; end
            cnt++;
        end
        cnt = 0;
        while (!bvalid && cnt < 10) begin tick(1); cnt++; end
        checks++;
        if (bvalid !== 1'b1) begin errors++; $display("FAIL b2b_bvalid got %b expected 1", bvalid); end
        awaddr = 32'h10; awvalid = 1'b1; wdata = 32'h0F; wvalid = 1'b1;
        stray = 0; bhigh = 0;
        for (int i = 0; i < 4; i++) begin
            if (awready || wready) stray++;
            if (bvalid) bhigh++;
            tick(1);
        end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL b2b_stray_accept got %0d expected 0", stray); end
        checks++;
        if (bhigh != 4) begin errors++; $display("FAIL b2b_bvalid_hold got %0d expected 4", bhigh); end
        bready = 1'b1;
        tick(1);
        bready = 1'b0;
        checks++;
        if (bvalid !== 1'b0) begin errors++; $display("FAIL b2b_single_b got %b expected 0", bvalid); end
        aw_done = 1'b0; w_done = 1'b0; cnt = 0;
        while (!(aw_done && w_done) && cnt < 20) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick(1);
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin wvalid = 1'b0; w_done = 1'b1; end
            cnt++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1; cnt = 0;
        while (!bvalid && cnt < 20) begin tick(1); cnt++; end
        checks++;
        if (bvalid !== 1'b1) begin errors++; $display("FAIL b2b_second_b got %b expected 1", bvalid); end
        tick(1);
        bready = 1'b0;
        axi_read(32'h14, d);
        checks++;
        if (d !== 32'h55) begin errors++; $display("FAIL b2b_pol_hi got %h expected 00000055", d); end
        axi_read(32'h10, d);
        checks++;
        if (d !== 32'h0F) begin errors++; $display("FAIL b2b_pol_lo got %h expected 0000000f", d); end
    endtask

    task automatic test_all_high_reset();
        logic [31:0] d;
        rst_n = 1'b0;
        gpio_in = '1;
        tick(3);
        rst_n = 1'b1;
        tick(10);
        axi_read(32'h18, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL warm_status_lo got %h expected 00000000", d); end
        axi_read(32'h1C, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL warm_status_hi got %h expected 00000000", d); end
        axi_read(32'h00, d);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL warm_pin_lo got %h expected ffffffff", d); end
        axi_read(32'h0C, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL warm_ie_hi got %h expected 00000000", d); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL warm_irq got %b expected 0", irq); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; gpio_in = '0;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        #1;
        test_reset();
        test_rise_pin3();
        test_fall_pin40();
        test_w1c_collision();
        test_strobe();
        test_pin_ro();
        test_back_to_back();
        test_all_high_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
